// File: rtl/alt_seq_if.sv
// alt_seq_if: sample/mode inputs and detection/status outputs of the alternation monitor.
interface alt_seq_if #(
   parameter int ALT_LEN = 4,
   parameter int CNT_W   = 8
);
   localparam int RW = $clog2(ALT_LEN + 1);
   logic          en;
   logic          A;
   logic          overlap;
   logic          y;
   logic          stuck;
   logic [RW-1:0] run_len;
   logic [CNT_W-1:0] det_cnt;
   modport master (output en, A, overlap, input y, stuck, run_len, det_cnt);
   modport slave  (input en, A, overlap, output y, stuck, run_len, det_cnt);
endinterface

// File: rtl/alt_seq_detector.sv
// alt_seq_detector: counts consecutive toggles of A, pulses y on ALT_LEN of them, flags a stuck line.
module alt_seq_detector #(
   parameter int ALT_LEN   = 4,
   parameter int STUCK_LEN = 3,
   parameter int CNT_W     = 8
) (
   input logic      clk,
   input logic      rst,
   alt_seq_if.slave bus
);
   localparam int RW = $clog2(ALT_LEN + 1);
   localparam int SW = $clog2(STUCK_LEN + 1);
   typedef enum logic [1:0] {IDLE, TRACK, HOLD} state_t;
   state_t           state;
   logic             prev;
   logic [RW-1:0]    run;
   logic [SW-1:0]    same;
   logic [CNT_W-1:0] det;
   logic             y;
   logic             stuck;
   logic             toggle;
   assign toggle = bus.A != prev;
   assign bus.y = y;
   assign bus.stuck = stuck;
   assign bus.run_len = run;
   assign bus.det_cnt = det;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state <= IDLE;
         prev  <= 1'b0;
         run   <= '0;
         same  <= '0;
         y     <= 1'b0;
         stuck <= 1'b0;
         det   <= '0;
      end else if (!bus.en) begin
         y <= 1'b0;
      end else begin
         prev <= bus.A;
         y    <= 1'b0;
         if (state == IDLE) begin
            run   <= '0;
            same  <= SW'(1);
            state <= TRACK;
         end else if (state == HOLD) begin
            if (toggle) begin
               stuck <= 1'b0;
               run   <= RW'(1);
               same  <= SW'(1);
               state <= TRACK;
            end
         end else if (toggle) begin
            same <= SW'(1);
            if (int'(run) + 1 == ALT_LEN) begin
               y   <= 1'b1;
               det <= &det ? det : det + CNT_W'(1);
               run <= bus.overlap ? RW'(ALT_LEN - 1) : '0;
            end else begin
               run <= run + RW'(1);
            end
         end else begin
            run  <= '0;
            same <= same + SW'(1);
            if (int'(same) + 1 == STUCK_LEN) begin
               stuck <= 1'b1;
               state <= HOLD;
            end
         end
      end
endmodule

// File: tb/tb_alt_seq_detector.sv
// tb_alt_seq_detector: scoreboard bench with a run-length reference model of the alternation monitor.
module tb_alt_seq_detector;
   localparam int AL = 4, SL = 3, CW = 2;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;
   alt_seq_if #(.ALT_LEN(AL), .CNT_W(CW)) bus ();
   alt_seq_detector #(.ALT_LEN(AL), .STUCK_LEN(SL), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));
   typedef struct {logic y; logic stuck; int run; int det;} exp_t;
   exp_t q[$];
   int errs = 0, checks = 0;
   int m = 0, e = 0, det = 0;
   bit started = 0;
   logic pa = 1'b0;
   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d", n, act, expv);
      end
   endtask
   task automatic model_reset();
      m = 0; e = 0; det = 0; started = 0;
   endtask
   // called at a negedge: drive inputs, predict outputs after the next posedge, advance to next negedge
   task automatic step(input logic en, input logic a, input logic ov);
      exp_t x;
      bus.en = en; bus.A = a; bus.overlap = ov;
      x.y = 1'b0;
      if (!rst) model_reset();
      else if (en) begin
         if (!started) begin
            started = 1; m = 0; e = 1;
         end else if (a != pa) begin
            e = 1; m++;
            if (m == AL) begin
               x.y = 1'b1;
               det = (det == 2**CW - 1) ? det : det + 1;
               m = ov ? AL - 1 : 0;
            end
         end else begin
            m = 0; e = (e < SL) ? e + 1 : SL;
         end
         pa = a;
      end
      x.stuck = e >= SL;
      x.run = m;
      x.det = det;
      q.push_back(x);
      @(negedge clk);
   endtask
   task automatic restart();
      rst = 1'b0;
      step(1'b1, 1'b0, 1'b0);
      rst = 1'b1;
   endtask
   task automatic seq(input logic [15:0] bits, input int n, input logic ov);
      for (int i = n - 1; i >= 0; i--) step(1'b1, bits[i], ov);
   endtask
   always @(posedge clk) begin
      exp_t x;
      #1;
      if (q.size() > 0) begin
         x = q.pop_front();
         chk("y", bus.y, x.y);
         chk("stuck", bus.stuck, x.stuck);
         chk("run_len", bus.run_len, x.run);
         chk("det_cnt", bus.det_cnt, x.det);
      end
   end
   initial begin
      logic t;
      bus.en = 1'b0; bus.A = 1'b0; bus.overlap = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 3; i++) step(1'b1, i[0], 1'b0);
      chk("rst_hold_det", bus.det_cnt, 0);
      rst = 1'b1;
      seq(16'b010, 3, 1'b0);
      chk("mid_run_len", bus.run_len, 2);
      #2 rst = 1'b0;
      #1;
      chk("async_y", bus.y, 0);
      chk("async_stuck", bus.stuck, 0);
      chk("async_run", bus.run_len, 0);
      chk("async_det", bus.det_cnt, 0);
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      seq(16'b01010, 5, 1'b0);
      chk("nov_y", bus.y, 1);
      chk("nov_det1", bus.det_cnt, 1);
      chk("nov_run", bus.run_len, 0);
      seq(16'b1010, 4, 1'b0);
      chk("nov_det2", bus.det_cnt, 2);
      restart();
      seq(16'b010101, 6, 1'b1);
      chk("ov_y6", bus.y, 1);
      seq(16'b0, 1, 1'b1);
      chk("ov_y7", bus.y, 1);
      chk("ov_det", bus.det_cnt, 3);
      chk("ov_run", bus.run_len, 3);
      restart();
      seq(16'b111, 3, 1'b0);
      chk("stuck_set", bus.stuck, 1);
      chk("stuck_run", bus.run_len, 0);
      seq(16'b1, 1, 1'b0);
      chk("stuck_hold", bus.stuck, 1);
      seq(16'b0, 1, 1'b0);
      chk("stuck_clr", bus.stuck, 0);
      chk("stuck_exit_run", bus.run_len, 1);
      chk("stuck_exit_y", bus.y, 0);
      restart();
      seq(16'b0, 1, 1'b0);
      for (int i = 0; i < 10; i++) step(1'b0, i[0], 1'b0);
      chk("gate_run", bus.run_len, 0);
      chk("gate_y", bus.y, 0);
      step(1'b1, 1'b1, 1'b0);
      chk("gate_resume_run", bus.run_len, 1);
      restart();
      seq(16'b010101010, 9, 1'b1);
      chk("sat_det", bus.det_cnt, 3);
      chk("sat_y", bus.y, 1);
      restart();
      t = 1'b0;
      for (int i = 0; i < 600; i++) begin
         rst = ($urandom % 60) != 0;
         if ($urandom % 4 != 0) t = ~t;
         step(($urandom % 5) != 0, t, $urandom % 2);
      end
      rst = 1'b1;
      step(1'b0, 1'b0, 1'b0);
      chk("queue_empty", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/alt_seq_detector.md
Name: alt_seq_detector

Overview:
- Parametrised successor to the two-case oscillating FSM.
- Samples serial input A on enabled clock edges and tracks consecutive alternations (A toggling sample to sample).
- Pulses y when ALT_LEN consecutive alternations are seen, with selectable overlapping or non-overlapping detection.
- Also flags a stuck input (A constant for STUCK_LEN samples) and keeps a saturating detection count. Sits on the control-path FSM layer as a line-activity monitor.

Parameters:
- ALT_LEN, 4, consecutive transitions required for a detection; legal range 2..255.
- STUCK_LEN, 3, consecutive equal samples (counting the first) that assert stuck; legal range 2..255.
- CNT_W, 8, width of the detection counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  sample enable; when low, all state holds.
- A  input  1  serial data sample.
- overlap  input  1  mode select: 1 = overlapping detection, 0 = restart after each detection.
- y  output  1  registered one-cycle detection pulse.
- stuck  output  1  registered level: A has been constant for at least STUCK_LEN samples.
- run_len  output  $clog2(ALT_LEN+1)  current alternation run length.
- det_cnt  output  CNT_W  saturating count of detections.

Behaviour:
- Reset (rst=0, asynchronous, takes effect immediately, including mid-run):
  - state=IDLE, prev=0, run=0, same=0.
  - y=0, stuck=0, run_len=0, det_cnt=0.
- en=0 at an edge: prev, run, same, state, stuck and det_cnt hold; y is cleared to 0. A is ignored.
- y is 1 only for the single cycle after the edge on which a detection sample is taken.
- FSM states: IDLE, TRACK, HOLD. The rules below apply on edges with en=1.
- IDLE:
  - prev<=A, run<=0, same<=1, go to TRACK.
  - No detection is possible on this first sample.
- TRACK, when A != prev (a transition):
  - same<=1.
  - If run+1 == ALT_LEN: y<=1 and det_cnt<=det_cnt+1, saturating at all-ones. run<=ALT_LEN-1 if overlap=1, else run<=0.
  - Otherwise run<=run+1.
- TRACK, when A == prev:
  - run<=0, same<=same+1.
  - If same+1 == STUCK_LEN: stuck<=1, go to HOLD.
- prev<=A on every enabled sample in every state.
- HOLD:
  - When A == prev: stay in HOLD. same saturates at STUCK_LEN; stuck stays 1.
  - When A != prev: stuck<=0, run<=1, same<=1, go to TRACK. No detection can occur on this edge.
- overlap is sampled on the detection edge only; changing it mid-run has no other effect.
- run_len always reflects the run register, so it never exceeds ALT_LEN-1 when observed.
- det_cnt saturation: at all-ones, further detections still pulse y but the count does not change.
- Detection and stuck are mutually exclusive on any single edge: a transition clears same, and an equal sample clears run.
- Latency: y appears 1 cycle after the clock edge that samples the ALT_LEN-th consecutive transition.

Test Plan:
- Reset: hold rst=0 for 3 cycles while toggling A and en=1 → y=0, stuck=0, run_len=0, det_cnt=0 throughout. Then assert rst=0 mid-run (run_len=2) → all outputs 0 immediately, before the next clock edge.
- Non-overlap (ALT_LEN=4, overlap=0, en=1): A=0,1,0,1,0 → y pulses once after the 5th sample, det_cnt=1, run_len=0. Continue A=1,0,1,0 → second pulse after the 9th sample, det_cnt=2.
- Overlap (overlap=1): A=0,1,0,1,0,1,0 → y high after samples 5, 6 and 7 (three back-to-back cycles), det_cnt=3, run_len=3.
- Stuck (STUCK_LEN=3): A=1,1,1 → stuck=1 after the 3rd sample, run_len=0. Then A=1 → stuck stays 1. Then A=0 → stuck=0, run_len=1, y=0.
- Enable gating: capture A=0, then en=0 while A toggles for 10 cycles → run_len, det_cnt and stuck unchanged, y=0. With en=1 and A=1 → run_len=1.
- Saturation (CNT_W=2, overlap=1): 5 consecutive detections → y pulses 5 times, det_cnt ends at 3.
